// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stalls, flushes, memory wait, forwarding.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] ID_rs1,
   input  logic [4:0] ID_rs2,
   input  logic [4:0] DE_rs1,
   input  logic [4:0] DE_rs2,
   input  logic [4:0] DE_rd,
   input  logic       DE_MemRead,
   input  logic       EX_BranchTaken,
   input  logic [4:0] EM_rd,
   input  logic       EM_RegWrite,
   input  logic       EM_MemRead,
   input  logic       EM_MemWrite,
   input  logic       mem_ready,
   input  logic [4:0] WB_RD,
   input  logic       WB_RegWrite,
   output logic       pc_en,
   output logic       IFID_en,
   output logic       IFID_flush,
   output logic       IDEX_en,
   output logic       IDEX_flush,
   output logic       EXMEM_en,
   output logic       MEMWB_bubble,
   output logic       mem_req,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StErr     = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             mem_access, load_use, flow, fwd_on;

   assign mem_access = EM_MemRead | EM_MemWrite;
   assign load_use   = DE_MemRead && (DE_rd != 5'd0) && ((DE_rd == ID_rs1) || (DE_rd == ID_rs2));
   assign mem_err    = mem_err_q;

   always_comb begin
      pc_en        = 1'b1;
      IFID_en      = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_en      = 1'b1;
      IDEX_flush   = 1'b0;
      EXMEM_en     = 1'b1;
      MEMWB_bubble = 1'b0;
      mem_req      = 1'b0;
      flow         = 1'b0;
      fwd_on       = 1'b0;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_err_d    = mem_err_q;

      if (!reset) begin
         pc_en        = 1'b0;
         IFID_en      = 1'b0;
         IFID_flush   = 1'b1;
         IDEX_en      = 1'b0;
         IDEX_flush   = 1'b1;
         EXMEM_en     = 1'b0;
         MEMWB_bubble = 1'b1;
         state_d      = StRun;
         wait_cnt_d   = '0;
         mem_err_d    = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               fwd_on  = 1'b1;
               mem_req = mem_access;
               if (mem_access && !mem_ready) begin
                  pc_en        = 1'b0;
                  IFID_en      = 1'b0;
                  IDEX_en      = 1'b0;
                  EXMEM_en     = 1'b0;
                  MEMWB_bubble = 1'b1;
                  state_d      = StMemWait;
                  wait_cnt_d   = CNT_W'(1);
               end else begin
                  flow = 1'b1;
               end
            end
            StMemWait: begin
               fwd_on  = 1'b1;
               mem_req = 1'b1;
               if (mem_ready) begin
                  flow       = 1'b1;
                  state_d    = StRun;
                  wait_cnt_d = '0;
               end else begin
                  pc_en        = 1'b0;
                  IFID_en      = 1'b0;
                  IDEX_en      = 1'b0;
                  EXMEM_en     = 1'b0;
                  MEMWB_bubble = 1'b1;
                  wait_cnt_d   = wait_cnt_q + 1'b1;
                  if (wait_cnt_q == TimeoutLast) begin
                     state_d   = StErr;
                     mem_err_d = 1'b1;
                  end
               end
            end
            StErr: begin
               pc_en        = 1'b0;
               IFID_en      = 1'b0;
               IDEX_en      = 1'b0;
               EXMEM_en     = 1'b0;
               MEMWB_bubble = 1'b1;
               mem_err_d    = 1'b1;
            end
            default: state_d = StRun;
         endcase
      end

      // Branch and load-use only act when the pipeline is actually advancing.
      if (flow) begin
         if (EX_BranchTaken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
         end
      end
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (fwd_on) begin
         if (EM_RegWrite && (EM_rd != 5'd0) && (EM_rd == DE_rs1)) begin
            fwd_a = 2'b10;
         end else if (WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == DE_rs1)) begin
            fwd_a = 2'b01;
         end
         if (EM_RegWrite && (EM_rd != 5'd0) && (EM_rd == DE_rs2)) begin
            fwd_b = 2'b10;
         end else if (WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == DE_rs2)) begin
            fwd_b = 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q, flush_count_q;

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if ((state_q != StErr) && !pc_en) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if ((state_q == StRun) && IFID_flush) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (built with MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] ID_rs1, ID_rs2, DE_rs1, DE_rs2, DE_rd, EM_rd, WB_RD;
   logic       DE_MemRead, EX_BranchTaken, EM_RegWrite, EM_MemRead, EM_MemWrite;
   logic       mem_ready, WB_RegWrite;
   logic       pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble;
   logic       mem_req, mem_err;
   logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // {pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble, mem_req}
   logic [7:0] ctl;
   logic [1:0] st;
   logic [7:0] wcnt;
   assign ctl  = {pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble, mem_req};
   assign st   = dut.state_q;
   assign wcnt = dut.wait_cnt_q;

   localparam logic [7:0] CtlReset  = 8'b0010_1010;
   localparam logic [7:0] CtlIdle   = 8'b1101_0100;
   localparam logic [7:0] CtlLdUse  = 8'b0001_1100;
   localparam logic [7:0] CtlMemOk  = 8'b1101_0101;
   localparam logic [7:0] CtlBranch = 8'b1111_1100;
   localparam logic [7:0] CtlStall  = 8'b0000_0011;
   localparam logic [7:0] CtlRelBr  = 8'b1111_1101;
   localparam logic [7:0] CtlErr    = 8'b0000_0010;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .DE_rs1(DE_rs1), .DE_rs2(DE_rs2), .DE_rd(DE_rd),
      .DE_MemRead(DE_MemRead), .EX_BranchTaken(EX_BranchTaken),
      .EM_rd(EM_rd), .EM_RegWrite(EM_RegWrite), .EM_MemRead(EM_MemRead),
      .EM_MemWrite(EM_MemWrite), .mem_ready(mem_ready),
      .WB_RD(WB_RD), .WB_RegWrite(WB_RegWrite),
      .pc_en(pc_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush), .IDEX_en(IDEX_en),
      .IDEX_flush(IDEX_flush), .EXMEM_en(EXMEM_en), .MEMWB_bubble(MEMWB_bubble),
      .mem_req(mem_req), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ID_rs1 = 5'd0; ID_rs2 = 5'd0; DE_rs1 = 5'd0; DE_rs2 = 5'd0; DE_rd = 5'd0;
      EM_rd = 5'd0; WB_RD = 5'd0;
      DE_MemRead = 1'b0; EX_BranchTaken = 1'b0; EM_RegWrite = 1'b0;
      EM_MemRead = 1'b0; EM_MemWrite = 1'b0; mem_ready = 1'b1; WB_RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlReset) begin
         n_err++; $display("FAIL reset_ctl got %b want %b", ctl, CtlReset);
      end
      tick();
      reset = 1'b1;
      n_cmp++;
      if (st !== 2'd0 || wcnt !== 8'd0 || mem_err !== 1'b0) begin
         n_err++; $display("FAIL reset_regs got st=%0d cnt=%0d err=%b want 0/0/0", st, wcnt, mem_err);
      end
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlIdle) begin
         n_err++; $display("FAIL idle_ctl got %b want %b", ctl, CtlIdle);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle_inputs();
      DE_MemRead = 1'b1; DE_rd = 5'd0; ID_rs1 = 5'd0;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlIdle) begin
         n_err++; $display("FAIL load_use_x0 got %b want %b", ctl, CtlIdle);
      end
      tick();
      DE_rd = 5'd5; ID_rs2 = 5'd5;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlLdUse) begin
         n_err++; $display("FAIL load_use_stall got %b want %b", ctl, CtlLdUse);
      end
      tick();
      idle_inputs();
      EM_MemRead = 1'b1; EM_rd = 5'd5; mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlMemOk) begin
         n_err++; $display("FAIL load_use_after got %b want %b", ctl, CtlMemOk);
      end
      tick();
   endtask

   task automatic test_branch();
      idle_inputs();
      DE_MemRead = 1'b1; DE_rd = 5'd9; ID_rs1 = 5'd9; EX_BranchTaken = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlBranch) begin
         n_err++; $display("FAIL branch_flush got %b want %b", ctl, CtlBranch);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      idle_inputs();
      EM_MemRead = 1'b1; mem_ready = 1'b0; EX_BranchTaken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ctl !== CtlStall || st !== ((i == 0) ? 2'd0 : 2'd1) || wcnt !== 8'(i)) begin
            n_err++;
            $display("FAIL mem_wait_%0d got ctl=%b st=%0d cnt=%0d want ctl=%b st=%0d cnt=%0d",
                     i, ctl, st, wcnt, CtlStall, (i == 0) ? 0 : 1, i);
         end
         tick();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlRelBr) begin
         n_err++; $display("FAIL mem_release got %b want %b", ctl, CtlRelBr);
      end
      tick();
      idle_inputs();
      n_cmp++;
      if (st !== 2'd0 || wcnt !== 8'd0) begin
         n_err++; $display("FAIL mem_back_run got st=%0d cnt=%0d want 0/0", st, wcnt);
      end
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlIdle) begin
         n_err++; $display("FAIL mem_after_idle got %b want %b", ctl, CtlIdle);
      end
      tick();
   endtask

   task automatic test_timeout();
      idle_inputs();
      EM_MemWrite = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ctl !== CtlStall) begin
            n_err++; $display("FAIL timeout_stall_%0d got %b want %b", i, ctl, CtlStall);
         end
         tick();
         n_cmp++;
         if (mem_err !== (i == 4)) begin
            n_err++; $display("FAIL timeout_err_%0d got %b want %b", i, mem_err, (i == 4));
         end
      end
      mem_ready = 1'b1; EM_RegWrite = 1'b1; EM_rd = 5'd3; DE_rs1 = 5'd3;
      @(negedge clk);
      n_cmp++;
      if (mem_err !== 1'b1 || ctl !== CtlErr || fwd_a !== 2'b00 || st !== 2'd2) begin
         n_err++;
         $display("FAIL err_hold got err=%b ctl=%b fwd_a=%b st=%0d want 1/%b/00/2",
                  mem_err, ctl, fwd_a, st, CtlErr);
      end
      tick();
      n_cmp++;
      if (mem_err !== 1'b1) begin
         n_err++; $display("FAIL err_sticky got %b want 1", mem_err);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlReset || mem_err !== 1'b1) begin
         n_err++; $display("FAIL err_in_reset got ctl=%b err=%b want %b/1", ctl, mem_err, CtlReset);
      end
      tick();
      reset = 1'b1;
      n_cmp++;
      if (mem_err !== 1'b0 || st !== 2'd0) begin
         n_err++; $display("FAIL err_cleared got err=%b st=%0d want 0/0", mem_err, st);
      end
   endtask

   task automatic test_forwarding();
      idle_inputs();
      EM_rd = 5'd7; WB_RD = 5'd7; EM_RegWrite = 1'b1; WB_RegWrite = 1'b1;
      DE_rs1 = 5'd7; DE_rs2 = 5'd0;
      @(negedge clk);
      n_cmp++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         n_err++; $display("FAIL fwd_mem got a=%b b=%b want 10/00", fwd_a, fwd_b);
      end
      tick();
      EM_RegWrite = 1'b0; DE_rs2 = 5'd7;
      @(negedge clk);
      n_cmp++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
         n_err++; $display("FAIL fwd_wb got a=%b b=%b want 01/01", fwd_a, fwd_b);
      end
      tick();
      EM_RegWrite = 1'b1; EM_rd = 5'd0; WB_RD = 5'd0; DE_rs1 = 5'd0; DE_rs2 = 5'd0;
      @(negedge clk);
      n_cmp++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         n_err++; $display("FAIL fwd_x0 got a=%b b=%b want 00/00", fwd_a, fwd_b);
      end
      tick();
      EM_rd = 5'd12; WB_RD = 5'd13; DE_rs1 = 5'd13; DE_rs2 = 5'd12;
      @(negedge clk);
      n_cmp++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin
         n_err++; $display("FAIL fwd_split got a=%b b=%b want 01/10", fwd_a, fwd_b);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      EM_MemRead = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      EM_RegWrite = 1'b1; EM_rd = 5'd4; DE_rs1 = 5'd4; DE_rs2 = 5'd4;
      @(negedge clk);
      n_cmp++;
      if (st !== 2'd1 || fwd_a !== 2'b10 || wcnt !== 8'd2) begin
         n_err++; $display("FAIL wait_fwd got st=%0d a=%b cnt=%0d want 1/10/2", st, fwd_a, wcnt);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlReset || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         n_err++;
         $display("FAIL mid_reset_out got ctl=%b a=%b b=%b want %b/00/00", ctl, fwd_a, fwd_b, CtlReset);
      end
      tick();
      reset = 1'b1;
      idle_inputs();
      n_cmp++;
      if (st !== 2'd0 || wcnt !== 8'd0 || mem_err !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_regs got st=%0d cnt=%0d err=%b want 0/0/0", st, wcnt, mem_err);
      end
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlIdle) begin
         n_err++; $display("FAIL mid_reset_idle got %b want %b", ctl, CtlIdle);
      end
      tick();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      tick();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_forwarding();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage RISC-V pipeline. It drives the enable and flush of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It covers three cases:
- load-use hazards, with a one-cycle stall and bubble;
- taken-branch flushes;
- multi-cycle data-memory accesses, through a req/ready handshake with a timeout.
It also produces the EX-stage forwarding selects.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before error (legal range 2..255).
CNT_W, 8, width of the wait counter.

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-low reset (asserted when 0)
ID_rs1  in  5  rs1 of the instruction in ID
ID_rs2  in  5  rs2 of the instruction in ID
DE_rs1  in  5  rs1 of the instruction in EX
DE_rs2  in  5  rs2 of the instruction in EX
DE_rd  in  5  rd of the instruction in EX
DE_MemRead  in  1  EX instruction is a load
EX_BranchTaken  in  1  EX resolved a taken branch or jump
EM_rd  in  5  rd in MEM
EM_RegWrite  in  1  MEM instruction writes rd
EM_MemRead  in  1  MEM instruction is a load
EM_MemWrite  in  1  MEM instruction is a store
mem_ready  in  1  data memory completes the access this cycle
WB_RD  in  5  rd in WB
WB_RegWrite  in  1  WB instruction writes rd
pc_en  out  1  PC update enable
IFID_en  out  1  IF/ID load enable
IFID_flush  out  1  IF/ID clear
IDEX_en  out  1  ID/EX load enable
IDEX_flush  out  1  ID/EX loads a bubble (all controls 0)
EXMEM_en  out  1  EX/MEM load enable
MEMWB_bubble  out  1  MEM/WB loads RegWrite=0 and MemtoReg=0
mem_req  out  1  data memory request
fwd_a  out  2  EX operand A select: 00 = regfile, 01 = WB, 10 = MEM
fwd_b  out  2  EX operand B select, same encoding
mem_err  out  1  sticky memory-timeout error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. State, wait_cnt and mem_err are registered. All other outputs are combinational from the state and the inputs.
- Reset (reset=0 at a posedge clk): state goes to RUN, wait_cnt to 0, mem_err to 0.
- While reset=0, outputs are forced as follows:
  - pc_en, IFID_en, IDEX_en, EXMEM_en = 0
  - IFID_flush, IDEX_flush, MEMWB_bubble = 1
  - mem_req = 0, fwd_a = fwd_b = 00
- mem_access = EM_MemRead | EM_MemWrite.
- RUN defaults: all enables 1, flushes 0, MEMWB_bubble 0.
- RUN, mem_req: mem_req = mem_access.
- RUN, memory stall (mem_access & !mem_ready):
  - pc_en = IFID_en = IDEX_en = EXMEM_en = 0
  - MEMWB_bubble = 1
  - next state MEM_WAIT, wait_cnt = 1
  - This case has the highest priority; branch and load-use outputs are suppressed.
- RUN, taken branch (EX_BranchTaken, no memory stall): IFID_flush = 1, IDEX_flush = 1. The load-use stall is suppressed.
- RUN, load-use hazard:
  - Condition: DE_MemRead & DE_rd!=0 & (DE_rd==ID_rs1 | DE_rd==ID_rs2), with no branch and no memory stall.
  - Response: pc_en = 0, IFID_en = 0, IDEX_flush = 1 for exactly one cycle, since the load then advances to MEM.
- MEM_WAIT:
  - mem_req = 1. Enables stay 0 and MEMWB_bubble stays 1.
  - On mem_ready: outputs equal the RUN memory-complete case (all enables 1, MEMWB_bubble = 0); next state RUN, wait_cnt = 0.
  - Otherwise wait_cnt increments. If wait_cnt == MEM_TIMEOUT-1, next state is ERR.
- ERR:
  - mem_err = 1. All enables 0, MEMWB_bubble = 1, mem_req = 0.
  - Exit only by reset.
- A branch held in EX during a memory stall is flushed on the release cycle, because EX_BranchTaken is still asserted.
- Forwarding (combinational, active in RUN and MEM_WAIT; 00 in ERR and in reset):
  - fwd_a = 10 if EM_RegWrite & EM_rd!=0 & EM_rd==DE_rs1.
  - Else fwd_a = 01 if WB_RegWrite & WB_RD!=0 & WB_RD==DE_rs1.
  - Else fwd_a = 00. MEM has priority over WB.
  - fwd_b uses the same rules with DE_rs2.
- x0 never triggers a hazard or forwarding.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (32 bits) and flush_count (32 bits), both reset to 0 and both wrapping at 2^32.
  - stall_cycles increments on each cycle with pc_en=0 in RUN or MEM_WAIT.
  - flush_count increments on each cycle with IFID_flush=1 in RUN (not in reset).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Load-use: DE_MemRead=1, DE_rd=5, ID_rs2=5 in RUN. Required: one cycle with pc_en=0, IFID_en=0, IDEX_flush=1; all enables 1 on the next cycle.
2. Branch: EX_BranchTaken=1 and a load-use hazard asserted simultaneously. Required: IFID_flush=1, IDEX_flush=1, pc_en=1.
3. Memory wait: EM_MemRead=1, mem_ready low for 3 cycles then high. Required:
   - 3 cycles of enables 0, MEMWB_bubble=1, mem_req=1;
   - release cycle with enables 1 and MEMWB_bubble=0;
   - state returns to RUN.
4. Timeout: MEM_TIMEOUT=4, EM_MemWrite=1, mem_ready held 0. Required: mem_err=1 after 4 stall cycles; it stays 1 with mem_ready=1; it clears only after a reset=0 cycle.
5. Forwarding: EM_rd=WB_RD=7, both RegWrite=1, DE_rs1=7, DE_rs2=0. Required: fwd_a=10, fwd_b=00. Then set EM_RegWrite=0. Required: fwd_a=01.
6. Reset mid-MEM_WAIT: assert reset=0 for one edge. Required: state RUN, wait_cnt 0, mem_err 0, with all outputs at their forced reset values while reset=0.
